// File: rtl/ntt_vec_sequencer.sv
// Vector command sequencer for the NTT arithmetic unit: streams operands from RAM into the unit and writes results back.
// Optional build macro NTT_SEQ_PERF_EN enables the cumulative port-A write counter on perf_elems_o.
module ntt_vec_sequencer #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_opcode_i,
  input  logic [ADDR_W-1:0] cmd_src_a_i,
  input  logic [ADDR_W-1:0] cmd_src_b_i,
  input  logic [ADDR_W-1:0] cmd_src_w_i,
  input  logic [ADDR_W-1:0] cmd_dst_a_i,
  input  logic [ADDR_W-1:0] cmd_dst_b_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [63:0]       cmd_q_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_a_o,
  output logic [ADDR_W-1:0] rd_addr_b_o,
  output logic [ADDR_W-1:0] rd_addr_w_o,
  input  logic [63:0]       rd_data_a_i,
  input  logic [63:0]       rd_data_b_i,
  input  logic [63:0]       rd_data_w_i,
  output logic              wr_en_a_o,
  output logic              wr_en_b_o,
  output logic [ADDR_W-1:0] wr_addr_a_o,
  output logic [ADDR_W-1:0] wr_addr_b_o,
  output logic [63:0]       wr_data_a_o,
  output logic [63:0]       wr_data_b_o,
  output logic [2:0]        au_opcode_o,
  output logic [63:0]       au_q_o,
  output logic [63:0]       au_a_o,
  output logic [63:0]       au_b_o,
  output logic [63:0]       au_w_o,
  input  logic [63:0]       au_res1_i,
  input  logic [63:0]       au_res2_i,
  output logic [31:0]       perf_elems_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [2:0] OP_BF = 3'd3;

  state_e            state_q;
  logic [2:0]        op_q;
  logic [63:0]       q_q;
  logic [ADDR_W-1:0] dst_a_q, dst_b_q;
  logic [LEN_W-1:0]  len_q, idx_q, idx_d;
  logic              rd_en_q, drain_q;
  logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_b_q, rd_addr_w_q;
  logic              v1_q, v2_q;
  logic [ADDR_W-1:0] off1_q, off2_q;

  assign idx_d = idx_q + LEN_W'(1);

  // NOTE: async reset in the sensitivity list and <= for every state register, so
  // all flops update together at the edge and reset acts without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      q_q         <= '0;
      dst_a_q     <= '0;
      dst_b_q     <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      rd_en_q     <= 1'b0;
      drain_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      rd_addr_w_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            op_q        <= cmd_opcode_i;
            q_q         <= cmd_q_i;
            dst_a_q     <= cmd_dst_a_i;
            dst_b_q     <= cmd_dst_b_i;
            len_q       <= cmd_len_i;
            idx_q       <= '0;
            rd_addr_a_q <= cmd_src_a_i;
            rd_addr_b_q <= cmd_src_b_i;
            rd_addr_w_q <= cmd_src_w_i;
            if (cmd_len_i != '0) begin
              state_q <= S_RUN;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (idx_q == len_q - LEN_W'(1)) begin
            rd_en_q <= 1'b0;
            drain_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            idx_q       <= idx_d;
            rd_addr_a_q <= rd_addr_a_q + ADDR_W'(1);
            rd_addr_b_q <= rd_addr_b_q + ADDR_W'(1);
            rd_addr_w_q <= rd_addr_w_q + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          // Two cycles let the last read's data and result retire.
          drain_q <= 1'b1;
          if (drain_q) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Element index travels with its valid bit: read -> data -> result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      off1_q <= '0;
      off2_q <= '0;
    end else begin
      v1_q   <= rd_en_q;
      v2_q   <= v1_q;
      off1_q <= idx_q[ADDR_W-1:0];
      off2_q <= off1_q;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign rd_en_o     = rd_en_q;
  assign rd_addr_a_o = rd_addr_a_q;
  assign rd_addr_b_o = rd_addr_b_q;
  assign rd_addr_w_o = rd_addr_w_q;

  assign au_opcode_o = op_q;
  assign au_q_o      = q_q;
  assign au_a_o      = rd_data_a_i;
  assign au_b_o      = rd_data_b_i;
  assign au_w_o      = rd_data_w_i;

  // NOTE: write-side address/data are gated by the delayed valid so they read 0
  // whenever no write is in flight, including during reset.
  assign wr_en_a_o   = v2_q;
  assign wr_addr_a_o = v2_q ? dst_a_q + off2_q : '0;
  assign wr_data_a_o = v2_q ? au_res1_i : '0;
  assign wr_en_b_o   = v2_q && (op_q == OP_BF);
  assign wr_addr_b_o = wr_en_b_o ? dst_b_q + off2_q : '0;
  assign wr_data_b_o = wr_en_b_o ? au_res2_i : '0;

`ifdef NTT_SEQ_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       perf_q <= '0;
    else if (v2_q) perf_q <= perf_q + 32'd1;
  end
  assign perf_elems_o = perf_q;
`else
  assign perf_elems_o = '0;
`endif

endmodule

// File: tb/tb_ntt_vec_sequencer.sv
// Bench for ntt_vec_sequencer: RAM + arith-unit environment, cycle-timing and memory-image reference model.
// Honours NTT_SEQ_PERF_EN for the perf_elems expectation.
module tb_ntt_vec_sequencer;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 11;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef NTT_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, busy, done, rd_en, wr_en_a, wr_en_b;
  logic [2:0] cmd_opcode, au_opcode;
  logic [ADDR_W-1:0] cmd_src_a, cmd_src_b, cmd_src_w, cmd_dst_a, cmd_dst_b;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, rd_addr_w, wr_addr_a, wr_addr_b;
  logic [LEN_W-1:0] cmd_len;
  logic [63:0] cmd_q, au_q, au_a, au_b, au_w, au_res1, au_res2;
  logic [63:0] rd_data_a = '0, rd_data_b = '0, rd_data_w = '0;
  logic [63:0] wr_data_a, wr_data_b;
  logic [31:0] perf_elems;

  logic [63:0] coef [DEPTH];
  logic [63:0] tw   [DEPTH];

  int vectors = 0;
  int errors  = 0;
  int perf_exp = 0;

  always #5 clk = ~clk;

  ntt_vec_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_opcode_i(cmd_opcode),
    .cmd_src_a_i(cmd_src_a), .cmd_src_b_i(cmd_src_b), .cmd_src_w_i(cmd_src_w),
    .cmd_dst_a_i(cmd_dst_a), .cmd_dst_b_i(cmd_dst_b), .cmd_len_i(cmd_len), .cmd_q_i(cmd_q),
    .busy_o(busy), .done_o(done), .rd_en_o(rd_en),
    .rd_addr_a_o(rd_addr_a), .rd_addr_b_o(rd_addr_b), .rd_addr_w_o(rd_addr_w),
    .rd_data_a_i(rd_data_a), .rd_data_b_i(rd_data_b), .rd_data_w_i(rd_data_w),
    .wr_en_a_o(wr_en_a), .wr_en_b_o(wr_en_b), .wr_addr_a_o(wr_addr_a), .wr_addr_b_o(wr_addr_b),
    .wr_data_a_o(wr_data_a), .wr_data_b_o(wr_data_b),
    .au_opcode_o(au_opcode), .au_q_o(au_q), .au_a_o(au_a), .au_b_o(au_b), .au_w_o(au_w),
    .au_res1_i(au_res1), .au_res2_i(au_res2), .perf_elems_o(perf_elems)
  );

  // Arithmetic behaviour of the environment's arith unit.
  function automatic logic [63:0] alu1(input logic [2:0] op, input logic [63:0] a, b, w, q);
    if (q == 0) return '0;
    case (op)
      3'd0: return (a + b) % q;
      3'd1: return (a * b) % q;
      3'd2: return (a + q - b) % q;
      3'd3: return (a + (w * b) % q) % q;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [63:0] alu2(input logic [2:0] op, input logic [63:0] a, b, w, q);
    if (q == 0 || op != 3'd3) return '0;
    return (a + q - (w * b) % q) % q;
  endfunction

  // RAMs with one-cycle read latency, plus the registered arith unit.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= coef[rd_addr_a];
      rd_data_b <= coef[rd_addr_b];
      rd_data_w <= tw[rd_addr_w];
    end
    if (wr_en_a) coef[wr_addr_a] <= wr_data_a;
    if (wr_en_b) coef[wr_addr_b] <= wr_data_b;
    au_res1 <= alu1(au_opcode, au_a, au_b, au_w, au_q);
    au_res2 <= alu2(au_opcode, au_a, au_b, au_w, au_q);
  end

  task automatic fill(input logic [63:0] q);
    for (int k = 0; k < DEPTH; k++) begin
      coef[k] = 64'($urandom) % q;
      tw[k]   = 64'($urandom) % q;
    end
  endtask

  task automatic check_perf(input string name);
    logic [31:0] want;
    want = PERF ? 32'(perf_exp) : 32'd0;
    vectors++;
    if (perf_elems !== want) begin
      errors++;
      $display("FAIL %s perf_elems: got %0d want %0d", name, perf_elems, want);
    end
  endtask

  // Entry: at a negedge with the DUT idle. Exit: at the negedge of the idle cycle after done.
  task automatic run_cmd(input string name, input logic [2:0] op,
                         input logic [ADDR_W-1:0] sa, sb, sw, da, db,
                         input int len, input logic [63:0] q, input bit keep);
    logic [63:0] exp_mem [DEPTH];
    logic [5:0] obs, want;
    logic [ADDR_W-1:0] ea, ia, ib, iw;
    int dc;
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = coef[k];
    for (int i = 0; i < len; i++) begin
      ia = sa + ADDR_W'(i); ib = sb + ADDR_W'(i); iw = sw + ADDR_W'(i);
      exp_mem[da + ADDR_W'(i)] = alu1(op, coef[ia], coef[ib], tw[iw], q);
      if (op == 3'd3) exp_mem[db + ADDR_W'(i)] = alu2(op, coef[ia], coef[ib], tw[iw], q);
    end
    dc = (len == 0) ? 1 : len + 3;

    cmd_opcode = op; cmd_src_a = sa; cmd_src_b = sb; cmd_src_w = sw;
    cmd_dst_a = da; cmd_dst_b = db; cmd_len = LEN_W'(len); cmd_q = q; cmd_valid = 1'b1;
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_at_offer: got ready=%b busy=%b want ready=1 busy=0", name, cmd_ready, busy);
    end
    @(posedge clk);
    for (int c = 1; c <= dc; c++) begin
      @(negedge clk);
      obs  = {rd_en, wr_en_a, wr_en_b, done, busy, cmd_ready};
      want = {(c <= len), (c >= 3 && c <= len + 2), (op == 3'd3 && c >= 3 && c <= len + 2),
              (c == dc), (c < dc), 1'b0};
      vectors++;
      if (obs !== want) begin
        errors++;
        $display("FAIL %s strobes cycle %0d: got rd,wa,wb,done,busy,rdy=%b want %b", name, c, obs, want);
      end
      if (want[5]) begin
        vectors++;
        ea = ADDR_W'(c - 1);
        if ({rd_addr_a, rd_addr_b, rd_addr_w} !== {sa + ea, sb + ea, sw + ea}) begin
          errors++;
          $display("FAIL %s rd_addr cycle %0d: got %0d/%0d/%0d want %0d/%0d/%0d", name, c,
                   rd_addr_a, rd_addr_b, rd_addr_w, sa + ea, sb + ea, sw + ea);
        end
      end
      if (want[4]) begin
        vectors++;
        ea = ADDR_W'(c - 3);
        if (wr_addr_a !== da + ea || (op == 3'd3 && wr_addr_b !== db + ea)) begin
          errors++;
          $display("FAIL %s wr_addr cycle %0d: got %0d/%0d want %0d/%0d", name, c,
                   wr_addr_a, wr_addr_b, da + ea, db + ea);
        end
      end
      if (keep) begin
        cmd_opcode = 3'($urandom); cmd_len = LEN_W'($urandom); cmd_q = 64'($urandom);
        cmd_src_a = ADDR_W'($urandom); cmd_dst_a = ADDR_W'($urandom);
      end else if (c == 1) begin
        cmd_valid = 1'b0;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      vectors++;
      if (coef[k] !== exp_mem[k]) begin
        errors++;
        $display("FAIL %s mem[%0d]: got %0d want %0d", name, k, coef[k], exp_mem[k]);
      end
    end
    perf_exp += len;
    check_perf(name);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({cmd_ready, busy, done, rd_en, wr_en_a, wr_en_b} !== 6'b100000) begin
      errors++;
      $display("FAIL %s idle_after_done: got %b want 100000",
               name, {cmd_ready, busy, done, rd_en, wr_en_a, wr_en_b});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_len = '0; cmd_q = '0;
    cmd_src_a = '0; cmd_src_b = '0; cmd_src_w = '0; cmd_dst_a = '0; cmd_dst_b = '0;
    #1;
    vectors++;
    if ({cmd_ready, busy, done, rd_en, wr_en_a, wr_en_b} !== 6'b100000 ||
        {au_opcode, au_q, rd_addr_a, rd_addr_b, rd_addr_w, wr_addr_a, wr_addr_b,
         wr_data_a, wr_data_b, perf_elems} !== '0) begin
      errors++;
      $display("FAIL reset_state: got ready,busy,done,rd,wa,wb=%b au_op=%0d au_q=%0d perf=%0d want 100000 and zeros",
               {cmd_ready, busy, done, rd_en, wr_en_a, wr_en_b}, au_opcode, au_q, perf_elems);
    end
    perf_exp = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_example();
    logic [63:0] want;
    fill(64'd97);
    for (int i = 0; i < 4; i++) begin
      coef[i] = 64'(i + 1);
      coef[16 + i] = 64'(10 * (i + 1));
    end
    run_cmd("add_example", 3'd0, 10'd0, 10'd16, 10'd0, 10'd32, 10'd300, 4, 64'd97, 1'b0);
    for (int i = 0; i < 4; i++) begin
      want = 64'(11 * (i + 1));
      vectors++;
      if (coef[32 + i] !== want) begin
        errors++;
        $display("FAIL add_example_ram[%0d]: got %0d want %0d", 32 + i, coef[32 + i], want);
      end
    end
  endtask

  task automatic test_bf();
    fill(64'd12289);
    run_cmd("bf_len2", 3'd3, 10'd100, 10'd200, 10'd300, 10'd400, 10'd500, 2, 64'd12289, 1'b0);
  endtask

  task automatic test_len_zero();
    run_cmd("len_zero", 3'd1, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9, 0, 64'd17, 1'b0);
  endtask

  task automatic test_wrap();
    fill(64'd65521);
    run_cmd("addr_wrap", 3'd2, 10'd1022, 10'd1021, 10'd1023, 10'd1020, 10'd600, 4, 64'd65521, 1'b0);
  endtask

  task automatic test_inplace();
    fill(64'd40961);
    run_cmd("in_place", 3'd1, 10'd700, 10'd800, 10'd900, 10'd700, 10'd0, 9, 64'd40961, 1'b0);
  endtask

  task automatic test_back_to_back();
    fill(64'd257);
    run_cmd("b2b_first", 3'd0, 10'd10, 10'd60, 10'd110, 10'd160, 10'd210, 5, 64'd257, 1'b1);
    run_cmd("b2b_second", 3'd3, 10'd300, 10'd350, 10'd400, 10'd450, 10'd500, 6, 64'd257, 1'b0);
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] base;
    logic [63:0] q;
    int len;
    for (int n = 0; n < 20; n++) begin
      q    = 64'($urandom_range(65521, 2));
      len  = $urandom_range(40, 1);
      base = ADDR_W'($urandom);
      fill(q);
      run_cmd("random", 3'($urandom_range(7, 0)), base, base + 10'd256, ADDR_W'($urandom),
              base + 10'd512, base + 10'd768, len, q, 1'b0);
    end
  endtask

  task automatic test_abort();
    fill(64'd97);
    cmd_opcode = 3'd3; cmd_len = 11'd8; cmd_q = 64'd97; cmd_valid = 1'b1;
    cmd_src_a = 10'd0; cmd_src_b = 10'd50; cmd_src_w = 10'd100; cmd_dst_a = 10'd150; cmd_dst_b = 10'd200;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    vectors++;
    if (rd_en !== 1'b1 || wr_en_a !== 1'b1) begin
      errors++;
      $display("FAIL abort_precondition: got rd=%b wa=%b want 1 1", rd_en, wr_en_a);
    end
    rst = 1'b1;
    #1;
    perf_exp = 0;
    vectors++;
    if ({cmd_ready, busy, done, rd_en, wr_en_a, wr_en_b} !== 6'b100000) begin
      errors++;
      $display("FAIL abort_immediate: got %b want 100000", {cmd_ready, busy, done, rd_en, wr_en_a, wr_en_b});
    end
    check_perf("abort_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++;
      if ({cmd_ready, busy, done, rd_en, wr_en_a, wr_en_b} !== 6'b100000) begin
        errors++;
        $display("FAIL abort_quiet cycle %0d: got %b want 100000", c, {cmd_ready, busy, done, rd_en, wr_en_a, wr_en_b});
      end
    end
    run_cmd("after_abort_len8", 3'd0, 10'd0, 10'd50, 10'd100, 10'd150, 10'd200, 8, 64'd97, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add_example();
    test_bf();
    test_len_zero();
    test_wrap();
    test_inplace();
    test_back_to_back();
    test_random();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
